// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared datapath width, reset PC and fetch-entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int DPW = 32;

    localparam logic [DPW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [DPW-1:0] pc;
        logic [DPW-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous circular FIFO of fetch entries, registered head.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_one_cnt = (AW+1)'(1);
    localparam logic [AW-1:0] c_one_ptr = AW'(1);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A full queue may accept a push in the same cycle it pops.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_one_ptr;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_one_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one_cnt;
                2'b01:   r_count <= r_count - c_one_cnt;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : rv32i fetch front end: PC, credit-limited imem requests,
//                in-order response queue and redirect/discard handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [DPW-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int             FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [DPW-1:0]  redirect_pc_i,
    output logic            imem_req_o,
    output logic [DPW-1:0]  imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [DPW-1:0]  imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [DPW-1:0]  instrF_o,
    output logic [DPW-1:0]  PCF_o
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0]  c_one   = CW'(1);
    localparam logic [CW:0]    c_depth = (CW+1)'(FQ_DEPTH);
    localparam logic [DPW-1:0] c_step  = DPW'(4);

    logic [DPW-1:0] r_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_discard;

    fetch_entry_t   w_pend_push;
    fetch_entry_t   w_pend_head;
    logic           w_pend_full;
    logic           w_pend_empty;
    logic [CW-1:0]  w_pend_count;

    fetch_entry_t   w_iq_push_data;
    fetch_entry_t   w_iq_head;
    logic           w_iq_full;
    logic           w_iq_empty;
    logic [CW-1:0]  w_iq_count;
    logic           w_iq_push;
    logic           w_iq_pop;

    logic [CW:0]    w_credit_sum;
    logic           w_fire;
    logic           w_unused_ok;

    // In-flight requests plus queued instructions never exceed the queue
    // depth, so every response has a guaranteed slot.
    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_iq_count};
    assign imem_req_o   = !rst && !redirect_i && (w_credit_sum < c_depth);
    assign imem_addr_o  = r_pc;
    assign w_fire       = imem_req_o && imem_gnt_i;

    assign w_pend_push    = '{pc: r_pc, instr: '0};
    assign w_iq_push_data = '{pc: w_pend_head.pc, instr: imem_rdata_i};
    assign w_iq_push      = imem_rvalid_i && (r_discard == '0) && !redirect_i;
    assign w_iq_pop       = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o = !w_iq_empty;
    assign instrF_o      = w_iq_empty ? '0 : w_iq_head.instr;
    assign PCF_o         = w_iq_empty ? '0 : w_iq_head.pc;

    assign w_unused_ok = &{1'b0, w_pend_count, w_pend_head.instr, redirect_pc_i[1:0]};

    fetch_queue #(
        .DEPTH     (FQ_DEPTH)
    ) u_pend_q (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fire),
        .push_data (w_pend_push),
        .pop       (imem_rvalid_i),
        .clear     (1'b0),
        .head      (w_pend_head),
        .full      (w_pend_full),
        .empty     (w_pend_empty),
        .count     (w_pend_count)
    );

    fetch_queue #(
        .DEPTH     (FQ_DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (w_iq_push),
        .push_data (w_iq_push_data),
        .pop       (w_iq_pop),
        .clear     (redirect_i),
        .head      (w_iq_head),
        .full      (w_iq_full),
        .empty     (w_iq_empty),
        .count     (w_iq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            case ({w_fire, imem_rvalid_i})
                2'b10:   r_outstanding <= r_outstanding + c_one;
                2'b01:   r_outstanding <= r_outstanding - c_one;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect_i) begin
                r_pc <= {redirect_pc_i[DPW-1:2], 2'b00};
                // Whatever is still in flight after this cycle's response is stale.
                r_discard <= imem_rvalid_i ? (r_outstanding - c_one) : r_outstanding;
            end else begin
                if (w_fire) r_pc <= r_pc + c_step;
                if (imem_rvalid_i && (r_discard != '0)) r_discard <= r_discard - c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid_i && (r_outstanding == '0) && w_pend_empty));
            assert (!(w_iq_push && w_iq_full && !w_iq_pop && !redirect_i));
            assert (!(w_fire && w_pend_full && !imem_rvalid_i));
        end
    end

endmodule
`default_nettype wire
